// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mandelbrot_pkg                                                   |
// | Shared widths, calc FSM state type and escape threshold.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mandelbrot_pkg;

  localparam int ENGINE_DATA_WIDTH = 25;
  localparam int FRAC_BITS         = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } calc_state_t;

  // 4.0 expressed at product scaling (2*FRAC_BITS fractional bits)
  localparam logic signed [2*ENGINE_DATA_WIDTH:0] ESCAPE_THRESH =
    (2*ENGINE_DATA_WIDTH+1)'(4) <<< (2*FRAC_BITS);

endpackage
`default_nettype wire

// File: rtl/calc_stage_2_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | calc_stage_2_if                                                  |
// | Pixel request/result and stage-1 feedback bundle.                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface calc_stage_2_if #(
  parameter int W  = mandelbrot_pkg::ENGINE_DATA_WIDTH,
  parameter int IW = 16
);
  logic                 start;
  logic signed [W-1:0]  cr;
  logic signed [W-1:0]  ci;
  logic [IW-1:0]        max_iter;
  logic signed [W-1:0]  zr;
  logic signed [W-1:0]  zi;
  logic signed [W-1:0]  zr_next;
  logic signed [W-1:0]  zi_next;
  logic                 stage1_en;
  logic                 busy;
  logic                 done;
  logic                 escaped;
  logic [IW-1:0]        iter_count;

  modport slave (
    input  start, cr, ci, max_iter, zr, zi,
    output zr_next, zi_next, stage1_en, busy, done, escaped, iter_count
  );

  modport master (
    output start, cr, ci, max_iter, zr, zi,
    input  zr_next, zi_next, stage1_en, busy, done, escaped, iter_count
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mul.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fxp_mul                                                          |
// | Registered signed W x W -> 2W multiplier.                        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fxp_mul #(
  parameter int W = 25
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic signed [W-1:0]   a,
  input  wire logic signed [W-1:0]   b,
  output logic signed [2*W-1:0]      p
);
  localparam int PW = 2 * W;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] p_d;
  logic signed [PW-1:0] p_q;

  always_comb begin
    a_ext = PW'(a);
    b_ext = PW'(b);
    p_d   = a_ext * b_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;
endmodule
`default_nettype wire

// File: rtl/calc_stage_2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | calc_stage_2                                                     |
// | z^2 + c iteration control, escape detection and counting.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module calc_stage_2
  import mandelbrot_pkg::*;
#(
  parameter int ENGINE_DATA_WIDTH = mandelbrot_pkg::ENGINE_DATA_WIDTH,
  parameter int FRAC_BITS         = mandelbrot_pkg::FRAC_BITS,
  parameter int ITER_WIDTH        = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  calc_stage_2_if.slave  bus
);
  localparam int W   = ENGINE_DATA_WIDTH;
  localparam int IW  = ITER_WIDTH;
  localparam int PW1 = 2 * W + 1;
  localparam logic signed [PW1-1:0] THRESH = PW1'(4) <<< (2 * FRAC_BITS);

  calc_state_t          state_q, state_d;
  logic signed [W-1:0]  cr_q, cr_d;
  logic signed [W-1:0]  ci_q, ci_d;
  logic [IW-1:0]        max_iter_q, max_iter_d;
  logic [IW-1:0]        k_q, k_d;
  logic [IW-1:0]        iter_count_q, iter_count_d;
  logic                 done_q, done_d;
  logic                 escaped_q, escaped_d;

  logic signed [2*W-1:0] rr, ii, ri;
  logic signed [PW1-1:0] mag2, diff, diff_sh, ri_sh;
  logic signed [W-1:0]   zr_upd, zi_upd;
  logic                  esc;
  logic signed [W-1:0]   zr_next_c, zi_next_c;
  logic                  stage1_en_c;

  fxp_mul #(.W(W)) u_mul_rr (.clk(clk), .reset(reset), .a(bus.zr), .b(bus.zr), .p(rr));
  fxp_mul #(.W(W)) u_mul_ii (.clk(clk), .reset(reset), .a(bus.zi), .b(bus.zi), .p(ii));
  fxp_mul #(.W(W)) u_mul_ri (.clk(clk), .reset(reset), .a(bus.zr), .b(bus.zi), .p(ri));

  // Products are stable through UPD since z only changes at the end of UPD
  always_comb begin
    mag2    = PW1'(rr) + PW1'(ii);
    diff    = PW1'(rr) - PW1'(ii);
    diff_sh = diff >>> FRAC_BITS;
    ri_sh   = PW1'(ri) >>> (FRAC_BITS - 1);
    esc     = (mag2 > THRESH);
    zr_upd  = W'(diff_sh) + cr_q;
    zi_upd  = W'(ri_sh) + ci_q;
  end

  always_comb begin
    state_d      = state_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    max_iter_d   = max_iter_q;
    k_d          = k_q;
    iter_count_d = iter_count_q;
    done_d       = 1'b0;
    escaped_d    = escaped_q;
    zr_next_c    = '0;
    zi_next_c    = '0;
    stage1_en_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cr_d        = bus.cr;
          ci_d        = bus.ci;
          max_iter_d  = bus.max_iter;
          k_d         = '0;
          stage1_en_c = 1'b1;
          state_d     = MUL;
        end
      end
      MUL: state_d = UPD;
      UPD: begin
        if (esc || (k_q == max_iter_q)) begin
          done_d       = 1'b1;
          escaped_d    = esc;
          iter_count_d = k_q;
          state_d      = DONE;
        end else begin
          zr_next_c   = zr_upd;
          zi_next_c   = zi_upd;
          stage1_en_c = 1'b1;
          k_d         = k_q + IW'(1);
          state_d     = MUL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cr_q         <= '0;
      ci_q         <= '0;
      max_iter_q   <= '0;
      k_q          <= '0;
      iter_count_q <= '0;
      done_q       <= 1'b0;
      escaped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      max_iter_q   <= max_iter_d;
      k_q          <= k_d;
      iter_count_q <= iter_count_d;
      done_q       <= done_d;
      escaped_q    <= escaped_d;
    end
  end

  assign bus.zr_next    = zr_next_c;
  assign bus.zi_next    = zi_next_c;
  assign bus.stage1_en  = stage1_en_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.escaped    = escaped_q;
  assign bus.iter_count = iter_count_q;
endmodule
`default_nettype wire
